// File: rtl/stmm_pkg.sv
// Shared definitions for the StMM result write-back path.
//   stmm_wr_state_e : write-back FSM states
//   beats()         : number of SDRAM beats needed for an n-byte vector
//   last_be()       : byte-enable mask for the final (possibly partial) beat
package stmm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } stmm_wr_state_e;

  function automatic int unsigned beats(input int unsigned n, input int unsigned sdram_w);
    return (n + sdram_w / 8 - 1) / (sdram_w / 8);
  endfunction

  // Low-order bits enabled for the bytes that remain in the last beat.
  // Returned 64 bits wide; callers truncate to SDRAM_W/8.
  function automatic logic [63:0] last_be(input int unsigned n, input int unsigned sdram_w);
    int unsigned bpb;
    int unsigned tail;
    logic [63:0] m;
    bpb  = sdram_w / 8;
    tail = n - (beats(n, sdram_w) - 1) * bpb;
    m    = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < tail) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/stmm_result_writer.sv
// StMM result write-back engine.
// Captures one N-byte result vector on in_valid and writes it to SDRAM as
// ceil(N/(SDRAM_W/8)) consecutive Avalon-MM write beats starting at base_addr.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready capture handshake (in_ready high only when idle)
//   Y_in, base_addr   result vector (byte k at [8k+7:8k]) and its SDRAM byte address
//   avm_*             Avalon-MM write master
//   done              one-cycle pulse after the last beat is accepted
//   overrun           sticky flag: in_valid seen while busy (request dropped)
module stmm_result_writer
  import stmm_pkg::*;
#(
  parameter int unsigned N       = 176,
  parameter int unsigned SDRAM_W = 128,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*8-1:0]         Y_in,
  input  logic [ADDR_W-1:0]      base_addr,
  output logic [ADDR_W-1:0]      avm_address,
  output logic                   avm_write,
  output logic [SDRAM_W-1:0]     avm_writedata,
  output logic [SDRAM_W/8-1:0]   avm_byteenable,
  input  logic                   avm_waitrequest,
  output logic                   done,
  output logic                   overrun
);

  localparam int unsigned BPB   = SDRAM_W / 8;
  localparam int unsigned BEATS = beats(N, SDRAM_W);
  localparam int unsigned BUF_W = BEATS * SDRAM_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BPB-1:0]   LAST_BE  = BPB'(last_be(N, SDRAM_W));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  stmm_wr_state_e     state_q;
  logic [BUF_W-1:0]   buf_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (in_valid && state_q != IDLE) overrun_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Zero-extension fills the pad bytes of the final beat.
            buf_q   <= BUF_W'(Y_in);
            addr_q  <= base_addr;
            cnt_q   <= '0;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          // Nothing moves while stalled, so address/data/byteenable hold.
          if (!avm_waitrequest) begin
            buf_q  <= buf_q >> SDRAM_W;
            addr_q <= addr_q + ADDR_W'(BPB);
            cnt_q  <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // All outputs decode registered state only; no input-to-output paths.
  assign in_ready       = (state_q == IDLE);
  assign avm_write      = (state_q == WRITE);
  assign done           = (state_q == DONE);
  assign overrun        = overrun_q;
  assign avm_address    = addr_q;
  assign avm_writedata  = buf_q[SDRAM_W-1:0];
  assign avm_byteenable = !avm_write          ? '0 :
                          (cnt_q == LAST_CNT) ? LAST_BE : '1;

endmodule

// File: tb/tb_stmm_result_writer.sv
module tb_stmm_result_writer;

  localparam int N     = 176;
  localparam int W     = 128;
  localparam int AW    = 32;
  localparam int BPB   = 16;
  localparam int BEATS = 11;
  localparam int NS    = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            in_valid, in_ready;
  logic [N*8-1:0]  y_in;
  logic [AW-1:0]   base_addr, avm_address;
  logic            avm_write, avm_waitrequest, done, overrun;
  logic [W-1:0]    avm_writedata;
  logic [W/8-1:0]  avm_byteenable;

  logic            in_valid_s, in_ready_s;
  logic [NS*8-1:0] y_s;
  logic [AW-1:0]   base_s, avm_address_s;
  logic            avm_write_s, avm_waitrequest_s, done_s, overrun_s;
  logic [W-1:0]    avm_writedata_s;
  logic [W/8-1:0]  avm_byteenable_s;

  stmm_result_writer #(.N(N), .SDRAM_W(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Y_in(y_in), .base_addr(base_addr), .avm_address(avm_address),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .done(done), .overrun(overrun)
  );

  stmm_result_writer #(.N(NS), .SDRAM_W(W), .ADDR_W(AW)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .Y_in(y_s), .base_addr(base_s), .avm_address(avm_address_s),
    .avm_write(avm_write_s), .avm_writedata(avm_writedata_s),
    .avm_byteenable(avm_byteenable_s), .avm_waitrequest(avm_waitrequest_s),
    .done(done_s), .overrun(overrun_s)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0]  a;
    logic [W-1:0]   d;
    logic [W/8-1:0] be;
  } beat_t;

  beat_t got_q[$];

  // Reference: beat b carries vector bytes b*BPB .. b*BPB+BPB-1, zero/disabled past N.
  function automatic beat_t model_beat(input logic [N*8-1:0] y, input logic [AW-1:0] base,
                                       input int b);
    beat_t r;
    r.a  = base + AW'(b * BPB);
    r.d  = '0;
    r.be = '0;
    for (int j = 0; j < BPB; j++) begin
      int idx;
      idx = b * BPB + j;
      if (idx < N) begin
        r.d[j*8 +: 8] = y[idx*8 +: 8];
        r.be[j]       = 1'b1;
      end
    end
    return r;
  endfunction

  // Drives one transfer (cycle 0 = in_valid cycle) and checks every write cycle
  // against the model. inj_at: cycle of an extra in_valid pulse; rst_at: cycle
  // at which reset is asserted (transfer abandoned). Negative disables.
  task automatic run_xfer(input logic [N*8-1:0] y, input logic [AW-1:0] base,
                          input int stall_pct, input int inj_at, input int rst_at,
                          output int first_c, output int done_c, output int ndone);
    int c, tail, nacc;
    bit fin;
    beat_t e;
    got_q.delete();
    first_c = -1; done_c = -1; ndone = 0; fin = 0; tail = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; y_in = y; base_addr = base; avm_waitrequest = 1'b0; c = 0;
    while (c < 400 && !(fin && tail >= 4)) begin
      @(posedge clk); #1;
      c++;
      in_valid = (c == inj_at);
      if (c == inj_at) begin
        y_in      = ~y;
        base_addr = base ^ 32'h100;
      end
      avm_waitrequest = ($urandom_range(99) < stall_pct);
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("write_drops_in_reset", avm_write, 1'b0);
        check("ready_in_reset", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      nacc = got_q.size();
      if (!fin) check("in_ready_busy", in_ready, 1'b0);
      if (fin && tail == 0) check("in_ready_after_done", in_ready, 1'b1);
      if (first_c >= 0 && nacc < BEATS) check("no_gap_mid_burst", avm_write, 1'b1);
      if (nacc >= BEATS) check("no_extra_write", avm_write, 1'b0);
      if (avm_write && nacc < BEATS) begin
        if (first_c < 0) first_c = c;
        e = model_beat(y, base, nacc);
        check("beat_addr", avm_address, e.a);
        check("beat_data", avm_writedata, e.d);
        check("beat_be", avm_byteenable, e.be);
        if (!avm_waitrequest) got_q.push_back('{avm_address, avm_writedata, avm_byteenable});
      end
      if (fin) tail++;
      if (done) begin
        ndone++;
        if (done_c < 0) done_c = c;
        fin = 1;
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout: got no done expected done within 400 cycles");
    end
    in_valid = 1'b0;
    avm_waitrequest = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] exp_addr1;
    logic [AW-1:0] exp_addr_last;
    logic [W-1:0]  exp_d0;
    int            exp_first;
    int            exp_done;
  } vec_t;

  vec_t vecs[4];
  logic [N*8-1:0] ramp;
  logic [N*8-1:0] yr;
  int fc, dc, nd;

  initial begin
    vecs[0] = '{32'h0000_1000, 32'h0000_1010, 32'h0000_10A0,
                128'h0F0E0D0C0B0A09080706050403020100, 1, 12};
    vecs[1] = '{32'hFFFF_FFF0, 32'h0000_0000, 32'h0000_0090,
                128'h0F0E0D0C0B0A09080706050403020100, 1, 12};
    vecs[2] = '{32'h0000_0000, 32'h0000_0010, 32'h0000_00A0,
                128'h0F0E0D0C0B0A09080706050403020100, 1, 12};
    vecs[3] = '{32'h7FFF_FF80, 32'h7FFF_FF90, 32'h8000_0020,
                128'h0F0E0D0C0B0A09080706050403020100, 1, 12};
    for (int k = 0; k < N; k++) ramp[k*8 +: 8] = 8'(k);

    rst_n = 1'b0; in_valid = 1'b0; y_in = '0; base_addr = '0; avm_waitrequest = 1'b0;
    in_valid_s = 1'b0; y_s = '0; base_s = '0; avm_waitrequest_s = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_avm_write", avm_write, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_address", avm_address, '0);
    check("rst_data", avm_writedata, '0);
    check("rst_be", avm_byteenable, '0);
    check("rst_in_ready_s", in_ready_s, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Table: no stalls, fixed ramp, latency and address wrap.
    for (int i = 0; i < 4; i++) begin
      run_xfer(ramp, vecs[i].base, 0, -1, -1, fc, dc, nd);
      check("tbl_first_cycle", fc, vecs[i].exp_first);
      check("tbl_done_cycle", dc, vecs[i].exp_done);
      check("tbl_done_count", nd, 1);
      check("tbl_beat_count", got_q.size(), BEATS);
      if (got_q.size() == BEATS) begin
        check("tbl_addr1", got_q[1].a, vecs[i].exp_addr1);
        check("tbl_addr_last", got_q[BEATS-1].a, vecs[i].exp_addr_last);
        check("tbl_data0", got_q[0].d, vecs[i].exp_d0);
      end
    end
    check("no_overrun_yet", overrun, 1'b0);

    // Random data, random aligned base, 50% stalls.
    for (int i = 0; i < 4; i++) begin
      for (int w = 0; w < N / 4; w++) yr[w*32 +: 32] = $urandom;
      run_xfer(yr, {$urandom_range(32'hFFFF_FFFF, 0)} & 32'hFFFF_FFF0, 50, -1, -1, fc, dc, nd);
      check("rnd_done_count", nd, 1);
      check("rnd_beat_count", got_q.size(), BEATS);
    end

    // in_valid during beat 3: dropped, overrun set.
    for (int w = 0; w < N / 4; w++) yr[w*32 +: 32] = $urandom;
    run_xfer(yr, 32'h0000_4000, 0, 4, -1, fc, dc, nd);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_done_count", nd, 1);
    check("ovr_beat_count", got_q.size(), BEATS);
    check("ovr_done_cycle", dc, 12);

    // Reset during beat 5, then a full transfer.
    run_xfer(ramp, 32'h0000_1000, 0, -1, 6, fc, dc, nd);
    @(negedge clk);
    check("post_rst_ready", in_ready, 1'b1);
    check("post_rst_overrun", overrun, 1'b0);
    check("post_rst_write", avm_write, 1'b0);
    run_xfer(ramp, 32'h0000_1000, 0, -1, -1, fc, dc, nd);
    check("post_rst_beats", got_q.size(), BEATS);
    check("post_rst_done_cycle", dc, 12);

    // in_valid coinciding with done: dropped, overrun set.
    run_xfer(ramp, 32'h0000_2000, 0, 12, -1, fc, dc, nd);
    check("done_coll_overrun", overrun, 1'b1);
    check("done_coll_beats", got_q.size(), BEATS);
    check("done_coll_done_count", nd, 1);

    // N=20: two beats, partial last beat with zero pad.
    for (int w = 0; w < NS / 4; w++) y_s[w*32 +: 32] = $urandom;
    @(posedge clk); #1;
    in_valid_s = 1'b1; base_s = 32'h0000_2000;
    @(posedge clk); #1 in_valid_s = 1'b0;
    @(negedge clk);
    check("s_write0", avm_write_s, 1'b1);
    check("s_addr0", avm_address_s, 32'h0000_2000);
    check("s_data0", avm_writedata_s, y_s[127:0]);
    check("s_be0", avm_byteenable_s, 16'hFFFF);
    @(negedge clk);
    check("s_write1", avm_write_s, 1'b1);
    check("s_addr1", avm_address_s, 32'h0000_2010);
    check("s_data1", avm_writedata_s, {96'h0, y_s[159:128]});
    check("s_be1", avm_byteenable_s, 16'h000F);
    @(negedge clk);
    check("s_done", done_s, 1'b1);
    check("s_write_end", avm_write_s, 1'b0);
    @(negedge clk);
    check("s_ready_again", in_ready_s, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
